// File: rtl/add_accum_ctrl.sv
// Accumulation controller for the 64-bit carry-lookahead adder stage.
// Streams operands into the adder and collects the running sum plus a sticky carry flag.
module add_accum_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_op_valid,
    input  logic [63:0]      i_op_data,
    output logic             o_op_ready,
    output logic [63:0]      o_add1,
    output logic [63:0]      o_add2,
    input  logic [64:0]      i_result,
    output logic             o_done_valid,
    input  logic             i_done_ready,
    output logic [63:0]      o_sum,
    output logic             o_overflow,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [63:0]      r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_remaining;
    logic             w_xfer;
    logic             w_start;

    assign w_start = (r_state == IDLE) && i_start;
    assign w_xfer  = (r_state == ACCUM) && i_op_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (i_count == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_xfer && (r_remaining == CNT_W'(1))) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (i_done_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake flags come from state alone so no valid/ready input feeds straight through.
    always_comb begin
        o_op_ready   = 1'b0;
        o_done_valid = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            ACCUM: begin
                o_op_ready = 1'b1;
                o_busy     = 1'b1;
            end
            DONE: begin
                o_done_valid = 1'b1;
                o_busy       = 1'b1;
            end
            default: begin
                o_op_ready   = 1'b0;
                o_done_valid = 1'b0;
                o_busy       = 1'b0;
            end
        endcase
    end

    // The counter is only decremented in ACCUM, where it is always at least one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= '0;
        end else if (w_start) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_remaining <= i_count;
        end else if (w_xfer) begin
            r_acc       <= i_result[63:0];
            r_ovf       <= r_ovf | i_result[64];
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    assign o_add1     = r_acc;
    assign o_add2     = i_op_data;
    assign o_sum      = r_acc;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_add_accum_ctrl.sv
// Directed bench for add_accum_ctrl with a behavioural 65-bit adder in the loop.
module tb_add_accum_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic        opValid;
    logic [63:0] opData;
    logic        opReady;
    logic [63:0] add1;
    logic [63:0] add2;
    logic [64:0] result;
    logic        doneValid;
    logic        doneReady;
    logic [63:0] sum;
    logic        overflow;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0]      count;
        int               nOps;
        logic [3:0][63:0] ops;
        logic [63:0]      expSum;
        logic             expOvf;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    assign result = {1'b0, add1} + {1'b0, add2};

    add_accum_ctrl #(.CNT_W(16)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_count      (count),
        .i_op_valid   (opValid),
        .i_op_data    (opData),
        .o_op_ready   (opReady),
        .o_add1       (add1),
        .o_add2       (add2),
        .i_result     (result),
        .o_done_valid (doneValid),
        .i_done_ready (doneReady),
        .o_sum        (sum),
        .o_overflow   (overflow),
        .o_busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t makeVec(input logic [15:0] c, input int n,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] d, input logic [63:0] e,
                                     input logic [63:0] s, input logic o);
        vec_t v;
        v.count  = c;
        v.nOps   = n;
        v.ops[0] = a;
        v.ops[1] = b;
        v.ops[2] = d;
        v.ops[3] = e;
        v.expSum = s;
        v.expOvf = o;
        return v;
    endfunction

    // Runs one complete job with back-to-back operands and an immediately ready consumer.
    task automatic applyStimulus(input vec_t v, input string tag);
        int          cyc;
        logic [63:0] acc;
        cyc   = 0;
        acc   = '0;
        start = 1'b1;
        count = v.count;
        tick();
        cyc++;
        start = 1'b0;
        checkOutput({tag, " ready_after_start"}, 64'(opReady), 64'd1);
        checkOutput({tag, " busy_after_start"}, 64'(busy), 64'd1);
        for (int k = 0; k < v.nOps; k++) begin
            opValid = 1'b1;
            opData  = v.ops[k];
            #1;
            checkOutput({tag, " add2"}, add2, v.ops[k]);
            checkOutput({tag, " add1"}, add1, acc);
            checkOutput({tag, " no_done_early"}, 64'(doneValid), 64'd0);
            acc = acc + v.ops[k];
            tick();
            cyc++;
        end
        opValid = 1'b0;
        checkOutput({tag, " done_valid"}, 64'(doneValid), 64'd1);
        checkOutput({tag, " ready_in_done"}, 64'(opReady), 64'd0);
        checkOutput({tag, " sum"}, sum, v.expSum);
        checkOutput({tag, " overflow"}, 64'(overflow), 64'(v.expOvf));
        doneReady = 1'b1;
        tick();
        cyc++;
        doneReady = 1'b0;
        checkOutput({tag, " idle_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, " idle_done_valid"}, 64'(doneValid), 64'd0);
        checkOutput({tag, " cycles"}, 64'(cyc), 64'(v.nOps + 2));
    endtask

    initial begin
        int          gap;
        logic [63:0] acc;
        logic [63:0] stallOps [4];

        rst       = 1'b1;
        start     = 1'b0;
        count     = '0;
        opValid   = 1'b0;
        opData    = '0;
        doneReady = 1'b0;

        vecs[0] = makeVec(16'd3, 3, 64'd1, 64'd2, 64'd3, 64'd0, 64'd6, 1'b0);
        vecs[1] = makeVec(16'd2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0, 64'd1, 1'b1);
        vecs[2] = makeVec(16'd1, 1, 64'd5, 64'd0, 64'd0, 64'd0, 64'd5, 1'b0);
        vecs[3] = makeVec(16'd4, 4, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                          64'd1, 64'd0, 64'd1, 1'b1);
        vecs[4] = makeVec(16'd2, 2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                          64'd0, 64'd0, 64'h2222_2222_2222_2211, 1'b0);

        #12;
        checkOutput("reset op_ready", 64'(opReady), 64'd0);
        checkOutput("reset done_valid", 64'(doneValid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset sum", sum, 64'd0);
        checkOutput("reset overflow", 64'(overflow), 64'd0);
        checkOutput("reset add1", add1, 64'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Zero count goes straight to DONE without ever offering ready.
        start = 1'b1;
        count = 16'd0;
        tick();
        start = 1'b0;
        checkOutput("zero done_valid", 64'(doneValid), 64'd1);
        checkOutput("zero op_ready", 64'(opReady), 64'd0);
        checkOutput("zero sum", sum, 64'd0);
        checkOutput("zero overflow", 64'(overflow), 64'd0);
        tick();
        checkOutput("zero op_ready_held", 64'(opReady), 64'd0);
        doneReady = 1'b1;
        tick();
        doneReady = 1'b0;
        checkOutput("zero idle_busy", 64'(busy), 64'd0);

        // Backpressure in DONE, with a stray start and operand that must be ignored.
        applyStimulus(makeVec(16'd2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'd0, 64'd2, 1'b1),
                      "bp_setup");
        start = 1'b1;
        count = 16'd2;
        tick();
        start   = 1'b0;
        opValid = 1'b1;
        opData  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        opData = 64'd3;
        tick();
        opValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start   = 1'b1;
                count   = 16'd5;
                opValid = 1'b1;
                opData  = 64'd100;
            end else begin
                start   = 1'b0;
                opValid = 1'b0;
            end
            checkOutput("bp done_valid", 64'(doneValid), 64'd1);
            checkOutput("bp sum", sum, 64'd2);
            checkOutput("bp overflow", 64'(overflow), 64'd1);
            tick();
        end
        start     = 1'b0;
        opValid   = 1'b0;
        doneReady = 1'b1;
        tick();
        doneReady = 1'b0;
        checkOutput("bp idle_busy", 64'(busy), 64'd0);
        checkOutput("bp sum_kept", sum, 64'd2);
        tick();
        checkOutput("bp no_restart", 64'(busy), 64'd0);

        // Random valid gaps; o_add2 must follow i_op_data every cycle.
        stallOps = '{64'd10, 64'd20, 64'd30, 64'd40};
        acc   = '0;
        start = 1'b1;
        count = 16'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                opValid = 1'b0;
                opData  = {$urandom, $urandom};
                #1;
                checkOutput("stall add2_gap", add2, opData);
                checkOutput("stall ready_gap", 64'(opReady), 64'd1);
                checkOutput("stall sum_hold", sum, acc);
                tick();
            end
            opValid = 1'b1;
            opData  = stallOps[k];
            #1;
            checkOutput("stall add2", add2, stallOps[k]);
            acc = acc + stallOps[k];
            tick();
        end
        opValid = 1'b0;
        checkOutput("stall done_valid", 64'(doneValid), 64'd1);
        checkOutput("stall sum", sum, 64'd100);
        doneReady = 1'b1;
        tick();
        doneReady = 1'b0;

        // Reset after two of four operands drops the job.
        start = 1'b1;
        count = 16'd4;
        tick();
        start   = 1'b0;
        opValid = 1'b1;
        opData  = 64'd1;
        tick();
        opData = 64'd2;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid op_ready", 64'(opReady), 64'd0);
        checkOutput("rst_mid done_valid", 64'(doneValid), 64'd0);
        checkOutput("rst_mid busy", 64'(busy), 64'd0);
        checkOutput("rst_mid sum", sum, 64'd0);
        checkOutput("rst_mid overflow", 64'(overflow), 64'd0);
        checkOutput("rst_mid add1", add1, 64'd0);
        opValid = 1'b0;
        tick();
        checkOutput("rst_mid no_done", 64'(doneValid), 64'd0);
        rst = 1'b0;
        tick();
        applyStimulus(makeVec(16'd1, 1, 64'd7, 64'd0, 64'd0, 64'd0, 64'd7, 1'b0), "after_rst");

        // Maximum count must consume exactly 65535 operands.
        start = 1'b1;
        count = 16'hFFFF;
        tick();
        start   = 1'b0;
        opValid = 1'b1;
        opData  = 64'd1;
        for (int k = 0; k < 65535; k++) begin
            if (k == 65534) begin
                checkOutput("max no_done_early", 64'(doneValid), 64'd0);
                checkOutput("max sum_before_last", sum, 64'd65534);
            end
            tick();
        end
        opValid = 1'b0;
        checkOutput("max done_valid", 64'(doneValid), 64'd1);
        checkOutput("max sum", sum, 64'd65535);
        checkOutput("max overflow", 64'(overflow), 64'd0);
        doneReady = 1'b1;
        tick();
        doneReady = 1'b0;
        checkOutput("max idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
